icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache that sits directly upstream of the fetch stage. It answers the fetch stage's per-address read requests and reports a hit one cycle later. On a miss it issues a single-word request to the memory controller, fills the line when the word returns, and forwards that word to fetch. It holds one outstanding miss at a time and never returns stale data after reset.

---
 rtl/icache.sv | 145 ++++++++++++++
 tb/tb_icache.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache in front of fetch.
// Ports: clk, rst (sync, active-high); fetch side rdEn/rdAddr -> hit/instOutEn/inst;
// memory side memReq/memAddr -> memDone/memData.
// Optional macro ICACHE_FLUSH_EN adds input `flush` that invalidates all lines
// and abandons any pending miss.
module icache #(
    parameter int INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEn,
    input  logic [31:0] rdAddr,
    output logic        hit,
    output logic        instOutEn,
    output logic [31:0] inst,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memDone,
    input  logic [31:0] memData
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic        flush
`endif
);

    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t state, state_n;

    logic [DEPTH-1:0]   valid;
    logic [TAG_W-1:0]   tag_q  [DEPTH];
    logic [31:0]        data_q [DEPTH];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [INDEX_BITS-1:0] fidx;
    logic [TAG_W-1:0]      ftag;
    logic                  lookup_hit;
    logic                  fill;
    logic                  flush_i;

    logic        hit_n;
    logic        outen_n;
    logic [31:0] inst_n;
    logic        req_n;
    logic [31:0] addr_n;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, rdAddr[1:0]};

`ifdef ICACHE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign idx  = rdAddr[INDEX_BITS+1:2];
    assign tag  = rdAddr[31:INDEX_BITS+2];
    // The held miss address doubles as the latched fill index and tag.
    assign fidx = memAddr[INDEX_BITS+1:2];
    assign ftag = memAddr[31:INDEX_BITS+2];

    assign lookup_hit = valid[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_n = state;
        hit_n   = 1'b0;
        outen_n = 1'b0;
        inst_n  = inst;
        req_n   = memReq;
        addr_n  = memAddr;
        fill    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rdEn) begin
                    if (lookup_hit) begin
                        hit_n  = 1'b1;
                        inst_n = data_q[idx];
                    end else begin
                        req_n   = 1'b1;
                        addr_n  = {rdAddr[31:2], 2'b00};
                        state_n = MISS;
                    end
                end
            end
            MISS: begin
                if (memDone) begin
                    fill    = 1'b1;
                    req_n   = 1'b0;
                    outen_n = 1'b1;
                    inst_n  = memData;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Flush wins over any lookup or fill in the same cycle.
        if (flush_i) begin
            state_n = IDLE;
            hit_n   = 1'b0;
            outen_n = 1'b0;
            req_n   = 1'b0;
            inst_n  = inst;
            fill    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hit       <= 1'b0;
            instOutEn <= 1'b0;
            inst      <= 32'd0;
            memReq    <= 1'b0;
            memAddr   <= 32'd0;
        end else begin
            state     <= state_n;
            hit       <= hit_n;
            instOutEn <= outen_n;
            inst      <= inst_n;
            memReq    <= req_n;
            memAddr   <= addr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid <= '0;
        end else if (fill) begin
            valid[fidx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only visible through its valid bit.
    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_q[fidx]  <= ftag;
            data_q[fidx] <= memData;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache.
// Drives fetch and memory sides, checks outputs one delta after each edge.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdEn;
    logic [31:0] rdAddr;
    logic        hit;
    logic        instOutEn;
    logic [31:0] inst;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memDone;
    logic [31:0] memData;
`ifdef ICACHE_FLUSH_EN
    logic        flush;
`endif

    int pass_cnt;
    int total_cnt;

    icache #(.INDEX_BITS(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdEn     (rdEn),
        .rdAddr   (rdAddr),
        .hit      (hit),
        .instOutEn(instOutEn),
        .inst     (inst),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memDone  (memDone),
        .memData  (memData)
`ifdef ICACHE_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss on addr, return data on the earliest allowed cycle.
    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        rdEn   = 1'b1;
        rdAddr = a;
        tick();
        rdEn    = 1'b0;
        memDone = 1'b1;
        memData = d;
        tick();
        memDone = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if (hit !== 1'b0)
            $display("FAIL reset_hit got=%b exp=0", hit);
        else pass_cnt++;
        total_cnt++;
        if (instOutEn !== 1'b0)
            $display("FAIL reset_outen got=%b exp=0", instOutEn);
        else pass_cnt++;
        total_cnt++;
        if (inst !== 32'd0)
            $display("FAIL reset_inst got=%h exp=0", inst);
        else pass_cnt++;
        total_cnt++;
        if (memReq !== 1'b0 || memAddr !== 32'd0)
            $display("FAIL reset_mem got=%b/%h exp=0/0", memReq, memAddr);
        else pass_cnt++;
    endtask

    task automatic test_cold_miss();
        rdEn   = 1'b1;
        rdAddr = 32'h0000_0100;
        tick();
        rdEn = 1'b0;
        total_cnt++;
        if (memReq !== 1'b1 || memAddr !== 32'h100 || hit !== 1'b0)
            $display("FAIL cold_req got=%b/%h/%b exp=1/100/0",
                     memReq, memAddr, hit);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (memReq !== 1'b1 || instOutEn !== 1'b0)
            $display("FAIL cold_hold got=%b/%b exp=1/0", memReq, instOutEn);
        else pass_cnt++;
        tick();
        memDone = 1'b1;
        memData = 32'h0000_0513;
        tick();
        memDone = 1'b0;
        total_cnt++;
        if (instOutEn !== 1'b1 || inst !== 32'h513 || hit !== 1'b0 ||
            memReq !== 1'b0)
            $display("FAIL cold_done got=%b/%h/%b/%b exp=1/513/0/0",
                     instOutEn, inst, hit, memReq);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (instOutEn !== 1'b0 || inst !== 32'h513)
            $display("FAIL cold_pulse got=%b/%h exp=0/513", instOutEn, inst);
        else pass_cnt++;
    endtask

    task automatic test_refetch_hit();
        rdEn   = 1'b1;
        rdAddr = 32'h0000_0102;
        tick();
        rdEn = 1'b0;
        total_cnt++;
        if (hit !== 1'b1 || inst !== 32'h513 || memReq !== 1'b0 ||
            instOutEn !== 1'b0)
            $display("FAIL refetch got=%b/%h/%b/%b exp=1/513/0/0",
                     hit, inst, memReq, instOutEn);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (hit !== 1'b0)
            $display("FAIL refetch_pulse got=%b exp=0", hit);
        else pass_cnt++;
    endtask

    task automatic test_conflict();
        fill(32'h100, 32'h1111_1111);
        fill(32'h300, 32'h2222_2222);
        total_cnt++;
        if (instOutEn !== 1'b1 || inst !== 32'h2222_2222)
            $display("FAIL conflict_fill got=%b/%h exp=1/22222222",
                     instOutEn, inst);
        else pass_cnt++;
        rdEn   = 1'b1;
        rdAddr = 32'h100;
        tick();
        total_cnt++;
        if (memReq !== 1'b1 || memAddr !== 32'h100 || hit !== 1'b0)
            $display("FAIL conflict_evict got=%b/%h/%b exp=1/100/0",
                     memReq, memAddr, hit);
        else pass_cnt++;
        rdAddr = 32'h500;
        tick();
        rdEn = 1'b0;
        total_cnt++;
        if (memReq !== 1'b1 || memAddr !== 32'h100 || hit !== 1'b0)
            $display("FAIL miss_ignores_rd got=%b/%h/%b exp=1/100/0",
                     memReq, memAddr, hit);
        else pass_cnt++;
        memDone = 1'b1;
        memData = 32'h1111_1111;
        tick();
        memDone = 1'b0;
        total_cnt++;
        if (instOutEn !== 1'b1 || inst !== 32'h1111_1111)
            $display("FAIL conflict_refill got=%b/%h exp=1/11111111",
                     instOutEn, inst);
        else pass_cnt++;
        rdEn   = 1'b1;
        rdAddr = 32'h300;
        tick();
        rdEn = 1'b0;
        total_cnt++;
        if (memReq !== 1'b1 || hit !== 1'b0 || memAddr !== 32'h300)
            $display("FAIL conflict_300 got=%b/%b/%h exp=1/0/300",
                     memReq, hit, memAddr);
        else pass_cnt++;
        memDone = 1'b1;
        memData = 32'h2222_2222;
        tick();
        memDone = 1'b0;
        tick();
        memDone = 1'b1;
        memData = 32'hDEAD_BEEF;
        tick();
        memDone = 1'b0;
        total_cnt++;
        if (instOutEn !== 1'b0 || memReq !== 1'b0 || inst !== 32'h2222_2222)
            $display("FAIL idle_memdone got=%b/%b/%h exp=0/0/22222222",
                     instOutEn, memReq, inst);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs[0] = 32'h0;
        addrs[1] = 32'h4;
        addrs[2] = 32'h8;
        datas[0] = 32'hA0A0_0001;
        datas[1] = 32'hA4A4_0002;
        datas[2] = 32'hA8A8_0003;
        for (int i = 0; i < 3; i++) fill(addrs[i], datas[i]);
        rdEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rdAddr = addrs[i];
            tick();
            total_cnt++;
            if (hit !== 1'b1 || inst !== datas[i] || instOutEn !== 1'b0 ||
                memReq !== 1'b0)
                $display("FAIL b2b_%0d got=%b/%h/%b/%b exp=1/%h/0/0",
                         i, hit, inst, instOutEn, memReq, datas[i]);
            else pass_cnt++;
        end
        rdEn = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_miss();
        rdEn   = 1'b1;
        rdAddr = 32'h40;
        tick();
        rdEn = 1'b0;
        total_cnt++;
        if (memReq !== 1'b1 || memAddr !== 32'h40)
            $display("FAIL rmm_req got=%b/%h exp=1/40", memReq, memAddr);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (memReq !== 1'b0 || memAddr !== 32'd0 || inst !== 32'd0)
            $display("FAIL rmm_clear got=%b/%h/%h exp=0/0/0",
                     memReq, memAddr, inst);
        else pass_cnt++;
        memDone = 1'b1;
        memData = 32'hBAD0_0040;
        tick();
        memDone = 1'b0;
        total_cnt++;
        if (instOutEn !== 1'b0 || memReq !== 1'b0)
            $display("FAIL rmm_late_done got=%b/%b exp=0/0",
                     instOutEn, memReq);
        else pass_cnt++;
        rdEn   = 1'b1;
        rdAddr = 32'h40;
        tick();
        rdEn = 1'b0;
        total_cnt++;
        if (hit !== 1'b0 || memReq !== 1'b1)
            $display("FAIL rmm_refetch got=%b/%b exp=0/1", hit, memReq);
        else pass_cnt++;
        memDone = 1'b1;
        memData = 32'h0000_0040;
        tick();
        memDone = 1'b0;
        // 0x100 was valid before reset; it must miss now.
        rdEn   = 1'b1;
        rdAddr = 32'h100;
        tick();
        rdEn = 1'b0;
        total_cnt++;
        if (hit !== 1'b0 || memReq !== 1'b1)
            $display("FAIL rmm_valid_clr got=%b/%b exp=0/1", hit, memReq);
        else pass_cnt++;
        memDone = 1'b1;
        memData = 32'h0000_0100;
        tick();
        memDone = 1'b0;
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush();
        fill(32'h200, 32'h0000_0200);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rdEn   = 1'b1;
        rdAddr = 32'h200;
        tick();
        rdEn = 1'b0;
        total_cnt++;
        if (hit !== 1'b0 || memReq !== 1'b1)
            $display("FAIL flush_inval got=%b/%b exp=0/1", hit, memReq);
        else pass_cnt++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++;
        if (memReq !== 1'b0)
            $display("FAIL flush_miss got=%b exp=0", memReq);
        else pass_cnt++;
        memDone = 1'b1;
        memData = 32'hBAD0_0200;
        tick();
        memDone = 1'b0;
        total_cnt++;
        if (instOutEn !== 1'b0 || memReq !== 1'b0)
            $display("FAIL flush_late_done got=%b/%b exp=0/0",
                     instOutEn, memReq);
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst     = 1'b1;
        rdEn    = 1'b0;
        rdAddr  = 32'd0;
        memDone = 1'b0;
        memData = 32'd0;
`ifdef ICACHE_FLUSH_EN
        flush   = 1'b0;
`endif
        test_reset();
        test_cold_miss();
        test_refetch_hit();
        test_conflict();
        test_back_to_back();
        test_reset_mid_miss();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
